// File: rtl/linear_scheduler.sv
// linear_scheduler: grants the shared linear MAC datapath to the CMVN or the
// ReLU producer, streams the input element reads, routes the results to the
// owner's destination buffer and flags a watchdog error if the datapath stalls.
module linear_scheduler #(
    parameter int IN_LEN  = 20,
    parameter int OUT_LEN = 20,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_cmvn,
    input  logic        req_relu,
    output logic        gnt_cmvn,
    output logic        gnt_relu,
    output logic        done_cmvn,
    output logic        done_relu,
    output logic        src_rd_en,
    output logic [4:0]  src_rd_addr,
    output logic        lin_start,
    output logic [1:0]  lin_mode,
    input  logic        lin_in_ready,
    output logic        lin_in_valid,
    output logic [4:0]  lin_in_addr,
    output logic        lin_in_last,
    input  logic        lin_out_valid,
    input  logic [4:0]  lin_out_addr,
    input  logic [31:0] lin_out_data,
    output logic        dst_wr_en_cmvn,
    output logic        dst_wr_en_relu,
    output logic [4:0]  dst_wr_addr,
    output logic [31:0] dst_wr_data,
    output logic        busy,
    output logic        err,
    input  logic        err_clr
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    localparam logic OWN_CMVN = 1'b0;
    localparam logic OWN_RELU = 1'b1;

    // Terminal counts: a length of 32 maps to index 31, so no 6-bit counters.
    localparam logic [4:0]  LAST_IDX = 5'(IN_LEN - 1);
    localparam logic [4:0]  LAST_OUT = 5'(OUT_LEN - 1);
    localparam logic [15:0] WDOG_LIM = 16'(TIMEOUT - 1);

    logic [2:0]  r_state;
    logic        r_owner;
    logic        r_last_owner;
    logic [4:0]  r_idx;
    logic [4:0]  r_out_cnt;
    logic [15:0] r_wdog;
    logic        r_in_valid;
    logic [4:0]  r_in_addr;
    logic        r_in_last;
    logic        r_wr_en;
    logic [4:0]  r_wr_addr;
    logic [31:0] r_wr_data;
    logic        r_err;

    logic [2:0]  w_state_nxt;
    logic        w_granted;
    logic        w_active;
    logic        w_rd_en;
    logic        w_res_ok;
    logic        w_res_last;
    logic        w_wdog_trip;
    logic        w_pick_relu;

    assign w_granted   = (r_state == S_START) || (r_state == S_FEED) ||
                         (r_state == S_WAIT)  || (r_state == S_DONE);
    assign w_active    = (r_state == S_FEED) || (r_state == S_WAIT);
    assign w_rd_en     = (r_state == S_FEED) && lin_in_ready;
    assign w_res_ok    = w_active && lin_out_valid;
    assign w_res_last  = w_res_ok && (r_out_cnt == LAST_OUT);
    // wdog counts idle cycles; the one that would make it reach TIMEOUT trips.
    assign w_wdog_trip = w_active && !w_rd_en && !lin_out_valid && (r_wdog == WDOG_LIM);
    // Tie goes to whoever did not own the datapath last.
    assign w_pick_relu = req_relu && (!req_cmvn || (r_last_owner == OWN_CMVN));

    // Next-state selection for the job sequencer.
    always_comb begin
        // NOTE: default assignment first so every path drives w_state_nxt and no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (req_cmvn || req_relu) w_state_nxt = S_START;
            S_START: w_state_nxt = S_FEED;
            S_FEED: begin
                if (w_res_last)                           w_state_nxt = S_DONE;
                else if (w_wdog_trip)                     w_state_nxt = S_ERR;
                else if (w_rd_en && (r_idx == LAST_IDX))  w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_res_last)       w_state_nxt = S_DONE;
                else if (w_wdog_trip) w_state_nxt = S_ERR;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Latch the winner at arbitration; remember it as last owner when the job ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner      <= OWN_CMVN;
            r_last_owner <= OWN_RELU;
        end else begin
            if ((r_state == S_IDLE) && (req_cmvn || req_relu)) r_owner <= w_pick_relu;
            if ((r_state == S_DONE) || (r_state == S_ERR))     r_last_owner <= r_owner;
        end
    end

    // Input element index and result counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_out_cnt <= '0;
        end else if (r_state == S_START) begin
            r_idx     <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_rd_en)  r_idx     <= r_idx + 5'd1;
            if (w_res_ok) r_out_cnt <= r_out_cnt + 5'd1;
        end
    end

    // Idle-cycle watchdog: any read or result counts as progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         r_wdog <= '0;
        else if (r_state == S_START)        r_wdog <= '0;
        else if (w_active)                  r_wdog <= (w_rd_en || lin_out_valid) ? 16'd0 : r_wdog + 16'd1;
    end

    // Input valid pipeline, aligned with the 1-cycle source buffer read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_valid <= 1'b0;
            r_in_addr  <= '0;
            r_in_last  <= 1'b0;
        end else begin
            r_in_valid <= w_rd_en;
            r_in_last  <= w_rd_en && (r_idx == LAST_IDX);
            if (w_rd_en) r_in_addr <= r_idx;
        end
    end

    // Result routing register towards the owner's destination buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_res_ok;
            if (w_res_ok) begin
                r_wr_addr <= lin_out_addr;
                r_wr_data <= lin_out_data;
            end
        end
    end

    // Sticky error flag; a new trip beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           r_err <= 1'b0;
        else if (w_wdog_trip) r_err <= 1'b1;
        else if (err_clr)     r_err <= 1'b0;
    end

    assign gnt_cmvn       = w_granted && (r_owner == OWN_CMVN);
    assign gnt_relu       = w_granted && (r_owner == OWN_RELU);
    assign done_cmvn      = (r_state == S_DONE) && (r_owner == OWN_CMVN);
    assign done_relu      = (r_state == S_DONE) && (r_owner == OWN_RELU);
    assign src_rd_en      = w_rd_en;
    assign src_rd_addr    = r_idx;
    assign lin_start      = (r_state == S_START);
    assign lin_mode       = {1'b0, gnt_relu};
    assign lin_in_valid   = r_in_valid;
    assign lin_in_addr    = r_in_addr;
    assign lin_in_last    = r_in_last;
    assign dst_wr_en_cmvn = r_wr_en && (r_owner == OWN_CMVN);
    assign dst_wr_en_relu = r_wr_en && (r_owner == OWN_RELU);
    assign dst_wr_addr    = r_wr_addr;
    assign dst_wr_data    = r_wr_data;
    assign busy           = (r_state != S_IDLE);
    assign err            = r_err;

endmodule

// File: doc/linear_scheduler.md
# linear_scheduler

Sequencer and arbiter for the shared `linear` MAC datapath in the KWS inference chain. It grants the datapath to one of two vector producers: CMVN (first layer) and ReLU (hidden-layer feedback). For the granted job it:
- configures the datapath mode and streams the input element addresses;
- routes the datapath results to the owner's destination buffer;
- signals completion, or a watchdog error if the datapath stalls.

## Interface
- IN_LEN, 20, input vector length, 1..32
- OUT_LEN, 20, results expected per job, 1..32
- TIMEOUT, 1023, idle-cycle watchdog limit, 2..65535
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- req_cmvn / req_relu  in  1 each  job request; level, held until done
- gnt_cmvn / gnt_relu  out  1 each  ownership; one-hot or zero
- done_cmvn / done_relu  out  1 each  one-cycle job-complete pulse
- src_rd_en  out  1  read strobe to the owner's input buffer (1-cycle synchronous read)
- src_rd_addr  out  5  element index
- lin_start  out  1  one-cycle pulse; datapath clears its accumulator
- lin_mode  out  2  00 = CMVN, 01 = ReLU; held while granted
- lin_in_ready  in  1  datapath can accept one more element
- lin_in_valid  out  1  input element present on the selected data bus
- lin_in_addr  out  5  index of that element
- lin_in_last  out  1  with lin_in_valid on index IN_LEN-1
- lin_out_valid  in  1  datapath result strobe
- lin_out_addr  in  5  result index
- lin_out_data  in  32 signed  result, 1.7.24
- dst_wr_en_cmvn / dst_wr_en_relu  out  1 each  result write to the owner's buffer
- dst_wr_addr  out  5  result index
- dst_wr_data  out  32  result
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky watchdog flag
- err_clr  in  1  clears err

## Operation
- **States:** IDLE, START, FEED, WAIT, DONE, ERR.
- **IDLE:** on any sampled request, pick a winner and go to START.
  - Single requester: it wins.
  - Both requesting: the one not recorded in `last_owner` wins.
  - `last_owner` resets to RELU, so CMVN wins the first tie.
- **START** (1 cycle):
  - Assert the winner's gnt; gnt stays high through DONE.
  - Pulse lin_start; set lin_mode.
  - Clear idx, out_cnt and wdog.
  - Go to FEED.
- **FEED:**
  - Each cycle with lin_in_ready=1: src_rd_en=1, src_rd_addr=idx, idx++.
  - When lin_in_ready=0: src_rd_en=0 and idx holds.
  - After the read at idx=IN_LEN-1 is issued, go to WAIT.
- **Input valid pipeline:** lin_in_valid and lin_in_addr are src_rd_en and src_rd_addr delayed by one register. lin_in_last is set for addr IN_LEN-1.
  - The datapath guarantees acceptance of every element whose read was issued while ready was high.
- **Result routing:** every lin_out_valid in FEED or WAIT is registered to the owner's dst_wr_en, dst_wr_addr and dst_wr_data, then out_cnt++.
  - When out_cnt reaches OUT_LEN, go to DONE.
  - lin_out_valid in IDLE, START, DONE or ERR is dropped silently.
  - Results beyond OUT_LEN are not possible, because the state leaves WAIT.
- **DONE** (1 cycle): pulse the owner's done; update last_owner; go to IDLE. gnt falls on entry to IDLE.
- **Watchdog:**
  - wdog increments in FEED and WAIT.
  - It clears on src_rd_en, on lin_out_valid, and in START.
  - wdog == TIMEOUT leads to ERR.
- **ERR** (1 cycle):
  - Set err; no done pulse; update last_owner; go to IDLE.
  - If err_clr and an error-set occur in the same cycle, the set wins.
- **Dropped requests:** a request dropped while granted is ignored; the job runs to DONE.
- **Width rule:** idx, out_cnt and all addresses are 5 bits; lengths of 32 are handled by a terminal-count compare, not by overflow.

## Timing
- **Reset values:** every output is 0, including lin_mode=00. Also state=IDLE, last_owner=RELU, all counters 0.
- **Reset mid-job:** immediate return to IDLE with all outputs 0; no done is issued.
- **Request to start:** a request sampled at edge N gives gnt and lin_start in cycle N+1.
- **Feed timing with ready held high:**
  - src_rd_en in cycles N+2 .. N+IN_LEN+1.
  - lin_in_valid in cycles N+3 .. N+IN_LEN+2.
- **Result path:** dst_wr_* is one cycle after lin_out_valid.
- **Completion:** done is asserted in the same cycle as the final dst_wr_en; gnt falls one cycle later.
- **Gap between jobs:** gnt is low for at least one cycle, because the earliest next START is two cycles after DONE.

## Test plan
- **Single CMVN job:** IN_LEN=20, OUT_LEN=20, ready=1, model returns 20 results starting 5 cycles after last. Expect:
  - gnt_cmvn, lin_mode=00, lin_start at N+1;
  - lin_in_addr 0..19 contiguous, last on 19;
  - dst_wr_en_cmvn with addr and data matching;
  - done_cmvn coinciding with the 20th write.
- **Simultaneous req_cmvn=req_relu=1 after reset:** CMVN served first, then RELU (lin_mode=01), with at least one gnt-low cycle between. A third request from CMVN while RELU is pending is served after RELU.
- **Ready stall:** lin_in_ready low for 3 cycles at idx 7. Expect no src_rd_en during the stall, no duplicated or skipped lin_in_addr, and the run still ends with last=19.
- **Watchdog:** TIMEOUT=16, model gives no results. Expect ERR 16 cycles after the last read, err=1, gnt released, no done. err_clr clears err; the next request is served normally.
- **Reset mid-FEED:** assert rst_n low at idx 10. Expect all outputs 0 asynchronously. After release, a CMVN/RELU tie grants CMVN.
- **Stray results:** lin_out_valid in IDLE gives no dst_wr_en. A request dropped mid-job still completes with done.
